z_core_control_unit: RTL and testbench

- Multi-cycle sequencer for the Z-Core datapath.
- Takes `op` and `funct3` from the instruction decoder, which is combinational on the instruction register, plus `br_taken` from the ALU and the memory handshake.
- Drives all datapath enables and selects: IR latch, PC update, register-file write, ALU operand selects, write-back select and memory request.
- Sits between the decoder/ALU/register file and the single shared instruction/data memory port.

---
 rtl/z_core_ctrl_pkg.sv | 43 ++++
 rtl/z_core_mem_timeout.sv | 28 ++
 rtl/z_core_control_unit.sv | 128 ++++++++++++
 tb/tb_z_core_control_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/z_core_ctrl_pkg.sv
// z_core_ctrl_pkg: shared opcodes, FSM state encoding and datapath select codes for the Z-Core control unit.
package z_core_ctrl_pkg;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_ALU   = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_UIMM = 2'b11;

   localparam logic ALU_A_RS1 = 1'b0;
   localparam logic ALU_A_PC  = 1'b1;
   localparam logic ALU_B_RS2 = 1'b0;
   localparam logic ALU_B_IMM = 1'b1;

   // SYSTEM is deliberately absent: the core has no CSR/ECALL support and traps on it.
   function automatic logic is_legal(input logic [6:0] op);
      return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                        OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE};
   endfunction
endpackage

// File: rtl/z_core_mem_timeout.sv
// z_core_mem_timeout: counts stalled memory-request cycles and flags a timeout on the last allowed one.
module z_core_mem_timeout #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic active,
   input  logic ready,
   input  logic clr,
   output logic expired
);
   localparam logic       ENABLED = MEM_TIMEOUT != 0;
   localparam logic [7:0] LAST    = 8'(MEM_TIMEOUT - 1);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (clr || ready)
         cnt <= '0;
      else if (active)
         cnt <= cnt + 8'd1;
   end

   // A ready arriving on the last allowed cycle still completes normally.
   assign expired = ENABLED && active && !ready && cnt == LAST;
endmodule

// File: rtl/z_core_control_unit.sv
// z_core_control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving the Z-Core datapath,
// with sticky illegal-opcode and memory-timeout traps.
module z_core_control_unit
   import z_core_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       br_taken,
   input  logic       mem_ready,
   output logic       mem_valid,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       illegal,
   output logic       bus_err,
   output logic       halted
);
   state_t state, state_nxt;
   logic   expired;
   logic   a_sel, b_sel;
   logic   unused;

   // Branch conditions are resolved by the ALU, so funct3 carries no control information here.
   assign unused = ^funct3;
   assign a_sel  = (op == OPC_AUIPC || op == OPC_JAL) ? ALU_A_PC : ALU_A_RS1;
   assign b_sel  = (op == OPC_OP || op == OPC_BRANCH) ? ALU_B_RS2 : ALU_B_IMM;

   z_core_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
      .clk    (clk),
      .rstn   (rstn),
      .active (mem_valid),
      .ready  (mem_ready),
      .clr    (state_nxt != state),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         illegal <= illegal | (state == S_DECODE && !is_legal(op));
         bus_err <= bus_err | expired;
      end
   end

   always_comb begin
      state_nxt    = state;
      mem_valid    = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      alu_a_sel    = ALU_A_RS1;
      alu_b_sel    = ALU_B_RS2;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;
      halted       = 1'b0;
      unique case (state)
         S_FETCH: begin
            mem_valid = 1'b1;
            ir_we     = mem_ready;
            state_nxt = mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
         end
         S_DECODE:
            state_nxt = is_legal(op) ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            alu_a_sel = a_sel;
            alu_b_sel = b_sel;
            pc_we     = op == OPC_BRANCH || op == OPC_FENCE;
            pc_sel    = (op == OPC_BRANCH && br_taken) ? PC_IMM : PC_PLUS4;
            state_nxt = pc_we ? S_FETCH : (op == OPC_LOAD || op == OPC_STORE) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_valid    = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = op == OPC_STORE;
            alu_a_sel    = a_sel;
            alu_b_sel    = b_sel;
            pc_we        = mem_we && mem_ready;
            state_nxt    = mem_ready ? (mem_we ? S_FETCH : S_WB) : expired ? S_TRAP : S_MEM;
         end
         // Operand selects stay driven so the ALU result (JALR target, write-back value) is still valid.
         S_WB: begin
            alu_a_sel = a_sel;
            alu_b_sel = b_sel;
            rf_we     = 1'b1;
            pc_we     = 1'b1;
            wb_sel    = op == OPC_LOAD ? WB_MEM :
                        (op == OPC_JAL || op == OPC_JALR) ? WB_PC4 :
                        op == OPC_LUI ? WB_UIMM : WB_ALU;
            pc_sel    = op == OPC_JAL ? PC_IMM : op == OPC_JALR ? PC_ALU : PC_PLUS4;
            state_nxt = S_FETCH;
         end
         S_TRAP:
            halted = 1'b1;
         default:
            state_nxt = S_FETCH;
      endcase
      // Nothing leaves the unit while reset is held, including an in-flight write-back.
      if (!rstn) begin
         mem_valid    = 1'b0;
         mem_we       = 1'b0;
         mem_addr_sel = 1'b0;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         pc_sel       = PC_PLUS4;
         alu_a_sel    = ALU_A_RS1;
         alu_b_sel    = ALU_B_RS2;
         rf_we        = 1'b0;
         wb_sel       = WB_ALU;
         halted       = 1'b0;
      end
   end
endmodule

// File: tb/tb_z_core_control_unit.sv
// tb_z_core_control_unit: directed instruction traces; expected per-cycle outputs are generated from the
// instruction's phase list and compared every cycle, plus literal cycle/enable counts per instruction.
module tb_z_core_control_unit;
   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
   localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, OPI = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011, FENCE = 7'b0001111;
   localparam logic [14:0] ALU_M = 15'h00C0;

   logic clk = 1'b0, rstn = 1'b0;
   logic [6:0] op;
   logic [2:0] funct3;
   logic br_taken, mem_ready;
   logic mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we;
   logic illegal, bus_err, halted;
   logic [1:0] pc_sel, wb_sel;

   z_core_control_unit #(.MEM_TIMEOUT(16)) dut (
      .clk(clk), .rstn(rstn), .op(op), .funct3(funct3), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
      .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .halted(halted)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int c_rf = 0, c_pc = 0, c_ir = 0;
   logic [14:0] exp_v = '0, care = '0;
   bit chk_en = 1'b0;
   string tag = "init";
   logic [14:0] act_v;
   assign act_v = {mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                   rf_we, wb_sel, illegal, bus_err, halted};

   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if ((act_v & care) !== (exp_v & care)) begin
            n_fail++;
            $display("FAIL %s outputs: got %b want %b (care %b)", tag, act_v, exp_v, care);
         end
         c_rf += int'(rf_we);
         c_pc += int'(pc_we);
         c_ir += int'(ir_we);
      end
   end

   function automatic logic [14:0] v(bit mv, bit we, bit as, bit ir, bit pw, logic [1:0] ps,
                                     bit aa, bit ab, bit rf, logic [1:0] wb,
                                     bit ill = 0, bit be = 0, bit h = 0);
      return {mv, we, as, ir, pw, ps, aa, ab, rf, wb, ill, be, h};
   endfunction

   function automatic bit legal(logic [6:0] o);
      return o inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, FENCE};
   endfunction

   task automatic chk(string what, int got, int want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s %s: got %0d want %0d", tag, what, got, want);
      end
   endtask

   task automatic step(logic rdy, logic [14:0] e, bit alu_care);
      mem_ready = rdy;
      exp_v     = e;
      care      = alu_care ? '1 : ~ALU_M;
      chk_en    = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic trap_tail(bit ill, bit be, int n);
      for (int i = 0; i < n; i++) step(1'b0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ill, be, 1), 1'b0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tag  = "reset";
      step(1'b1, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      rstn = 1'b1;
   endtask

   // Generates one instruction's trace: fetch (fw stalls), decode, execute, optional mem (mw stalls), wb.
   task automatic instr(string name, logic [6:0] o, bit br, int fw, int mw,
                        int exp_cyc, int exp_ir, int exp_rf, int exp_pc);
      int cyc = 0, rf0 = c_rf, pc0 = c_pc, ir0 = c_ir;
      bit aa, ab, is_ld, is_st, rdy, tmo = 0;
      tag = name;
      aa = o == AUIPC || o == JAL;
      ab = !(o == OPR || o == BR);
      is_ld = o == LD;
      is_st = o == ST;
      for (int i = 0; ; i++) begin
         rdy = i == fw;
         step(rdy, v(1, 0, 0, rdy, 0, 0, 0, 0, 0, 0), 1'b0);
         cyc++;
         if (rdy) break;
         if (i == 15) begin tmo = 1; break; end
      end
      if (!tmo) begin
         op = o;
         step(1'b0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
         cyc++;
         if (!legal(o)) trap_tail(1, 0, 20);
         else begin
            br_taken = br;
            if (o == BR || o == FENCE) begin
               step(1'b0, v(0, 0, 0, 0, 1, (o == BR && br) ? 2'b01 : 2'b00, aa, ab, 0, 0), 1'b1);
               cyc++;
            end else begin
               step(1'b0, v(0, 0, 0, 0, 0, 0, aa, ab, 0, 0), 1'b1);
               cyc++;
               if (is_ld || is_st) begin
                  for (int j = 0; ; j++) begin
                     rdy = j == mw;
                     step(rdy, v(1, is_st, 1, 0, is_st && rdy, 0, aa, ab, 0, 0), 1'b1);
                     cyc++;
                     if (rdy) break;
                     if (j == 15) begin tmo = 1; break; end
                  end
               end
               if (!tmo && !is_st) begin
                  step(1'b0, v(0, 0, 0, 0, 1, o == JAL ? 2'b01 : o == JALR ? 2'b10 : 2'b00, aa, ab, 1,
                               is_ld ? 2'b01 : (o == JAL || o == JALR) ? 2'b10 : o == LUI ? 2'b11 : 2'b00),
                       1'b0);
                  cyc++;
               end
            end
         end
      end
      if (tmo) trap_tail(0, 1, 3);
      chk("cycles", cyc, exp_cyc);
      chk("ir_we count", c_ir - ir0, exp_ir);
      chk("rf_we count", c_rf - rf0, exp_rf);
      chk("pc_we count", c_pc - pc0, exp_pc);
   endtask

   initial begin
      int pc0, rf0;
      op = 7'h00; funct3 = 3'b000; br_taken = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tag = "in_reset";
      step(1'b1, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
      rstn = 1'b1;
      instr("addi",  OPI,   0, 0, 0, 4, 1, 1, 1);
      funct3 = 3'b010;
      instr("sw_w3", ST,    0, 0, 3, 7, 1, 0, 1);
      funct3 = 3'b000;
      instr("beq_t", BR,    1, 0, 0, 3, 1, 0, 1);
      instr("beq_n", BR,    0, 0, 0, 3, 1, 0, 1);
      funct3 = 3'b010;
      instr("lw",    LD,    0, 0, 0, 5, 1, 1, 1);
      instr("sw",    ST,    0, 0, 0, 4, 1, 0, 1);
      funct3 = 3'b000;
      instr("jalr",  JALR,  0, 0, 0, 4, 1, 1, 1);
      instr("jal",   JAL,   0, 2, 0, 6, 1, 1, 1);
      instr("lui",   LUI,   0, 0, 0, 4, 1, 1, 1);
      instr("auipc", AUIPC, 0, 0, 0, 4, 1, 1, 1);
      instr("add",   OPR,   0, 0, 0, 4, 1, 1, 1);
      instr("fence", FENCE, 0, 0, 0, 3, 1, 0, 1);
      instr("lw_w2", LD,    0, 1, 2, 8, 1, 1, 1);
      instr("bad7f", 7'h7f, 0, 0, 0, 2, 1, 0, 0);
      do_reset();
      instr("ecall", 7'h73, 0, 0, 0, 2, 1, 0, 0);
      do_reset();
      instr("fetch_tmo", OPR, 0, 99, 0, 16, 0, 0, 0);
      do_reset();
      instr("ready_at16", OPR, 0, 15, 0, 19, 1, 1, 1);
      instr("mem_tmo", LD, 0, 0, 99, 19, 1, 0, 0);
      do_reset();
      tag = "stall_pre_rst";
      for (int i = 0; i < 10; i++) step(1'b0, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      do_reset();
      instr("after_rst", OPI, 0, 15, 0, 19, 1, 1, 1);
      tag = "rst_in_wb";
      pc0 = c_pc;
      rf0 = c_rf;
      step(1'b1, v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0);
      op = OPI;
      step(1'b0, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      step(1'b0, v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
      do_reset();
      tag = "rst_in_wb";
      chk("pc_we count", c_pc - pc0, 0);
      chk("rf_we count", c_rf - rf0, 0);
      tag = "idle_fetch";
      step(1'b0, v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
